// File: rtl/pwm_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_pkg
//  Description : Shared types and helpers for the multi-channel PWM DAC.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_dac_pkg;

    // Timebase shape: sawtooth or triangle
    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    // Counting direction of the triangle timebase
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Terminal count for a counter of the given width (all ones)
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timebase
//  Description : Prescaler plus edge/center counter shared by all channels.
//                Latches the mode/prescale configuration at period boundaries
//                and flags the boundary and the first clock of each period.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_timebase
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_center_mode,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_boundary,
    output logic                  o_period_start,
    output logic [WIDTH-1:0]      o_cnt
);

    localparam logic [WIDTH-1:0]      c_MAX     = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0]      c_ONE     = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] c_PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_presc;
    mode_e                 r_mode;
    dir_e                  r_dir;
    dir_e                  w_dir_nxt;
    logic [WIDTH-1:0]      r_cnt;
    logic [WIDTH-1:0]      w_cnt_nxt;
    logic                  r_period_start;
    logic                  w_tick;
    logic                  w_last_edge;
    logic                  w_last_center;
    logic                  w_boundary;

    // Greater-or-equal so a prescale lowered while paused cannot strand the
    // prescaler above its terminal value.
    assign w_tick        = i_en && (r_pre >= r_presc);
    assign w_last_edge   = (r_cnt == c_MAX);
    // With a 1-bit counter the triangle peak is also the last step down.
    assign w_last_center = (r_cnt == c_ONE) && ((r_dir == DIR_DOWN) || (c_MAX == c_ONE));
    assign w_boundary    = w_tick && ((r_mode == MODE_CENTER) ? w_last_center : w_last_edge);

    // Prescaler: free-runs while enabled, restarts after every tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (i_en) begin
            r_pre <= w_tick ? '0 : (r_pre + c_PRE_ONE);
        end
    end

    // Counter/direction next-state: sawtooth or triangle, restart on boundary
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_boundary) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_tick) begin
            if (r_mode == MODE_EDGE) begin
                w_cnt_nxt = r_cnt + c_ONE;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt == c_MAX) begin
                    w_dir_nxt = DIR_DOWN;
                    w_cnt_nxt = r_cnt - c_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end else begin
                w_cnt_nxt = r_cnt - c_ONE;
            end
        end
    end

    // Counter/direction state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    // Active configuration follows the inputs while stopped, else only at boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MODE_EDGE;
            r_presc <= '0;
        end else if (!i_en || w_boundary) begin
            r_mode  <= mode_e'(i_center_mode);
            r_presc <= i_prescale;
        end
    end

    // Period-start pulse coincides with the first clock of cnt==0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
        end
    end

    assign o_boundary     = w_boundary;
    assign o_period_start = r_period_start;
    assign o_cnt          = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pwm_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_multi
//  Description : Multi-channel PWM DAC. Shared timebase, per-channel
//                double-buffered duty registers written over a valid/ready
//                port, commits at period boundaries, registered comparators.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_dac_multi
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  center_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  wr_valid,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    output logic                  wr_ready,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start,
    output logic [WIDTH-1:0]      cnt
);

    logic                w_boundary;
    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_pend;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_center_mode  (center_mode),
        .i_prescale     (prescale),
        .o_boundary     (w_boundary),
        .o_period_start (period_start),
        .o_cnt          (cnt)
    );

    // An out-of-range channel selects nothing, so it is always ready and dropped.
    assign wr_ready = ~|(w_sel & w_pend);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_shadow;
        logic [WIDTH-1:0] r_active;
        logic             r_pending;
        logic             r_pwm;
        logic             w_acc;

        assign w_sel[i]   = (wr_ch == CH_W'(i));
        assign w_pend[i]  = r_pending;
        assign w_acc      = wr_valid && w_sel[i] && !r_pending;
        assign pwm_out[i] = r_pwm;

        // Duty buffering: stopped or boundary-coincident writes bypass the shadow
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_shadow  <= '0;
                r_active  <= '0;
                r_pending <= 1'b0;
            end else if (w_acc) begin
                r_shadow <= wr_duty;
                if (!en || w_boundary) begin
                    r_active  <= wr_duty;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end else if (w_boundary && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end

        // Comparator: output frozen together with the timebase while stopped
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pwm <= 1'b0;
            end else if (en) begin
                r_pwm <= (cnt < r_active);
            end
        end
    end

endmodule
`default_nettype wire
